// File: rtl/safe_mac_sequencer.sv
// Dot-product sequencer around one saturating Qm.n multiplier and one saturating adder.
// Optional sticky saturation flag on sat_o when SAFE_MAC_SAT_FLAG_EN is defined.
module safe_mac_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int N_SIZE    = 14,
    parameter int M_SIZE    = WORD_SIZE - N_SIZE,
    parameter int LENGTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [WORD_SIZE-1:0] bias_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WORD_SIZE-1:0] data_o
`ifdef SAFE_MAC_SAT_FLAG_EN
    ,
    output logic                 sat_o
`endif
);

    // Handshake: a pair is taken when valid_i & ready_o at a rising edge; a result
    // leaves when valid_o & ready_i at a rising edge. Both outputs are registered.
    localparam int CW      = $clog2(LENGTH + 1);
    localparam int PW      = 2 * WORD_SIZE;
    localparam int TOP_LSB = N_SIZE + M_SIZE - 1;

    localparam logic [WORD_SIZE-1:0] MAX_V = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] MIN_V = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WORD_SIZE-1:0]   acc_r;
    logic [WORD_SIZE-1:0]   prod_r;
    logic                   prod_v_r;

    logic signed [PW-1:0]   a_x, b_x, p, q;
    logic [WORD_SIZE:0]     s;
    logic                   mult_sat, add_sat;
    logic [WORD_SIZE-1:0]   mult_res, add_res;
    logic                   accept;

    assign accept = valid_i & ready_o;

    always_comb begin
        a_x = PW'($signed(a_i));
        b_x = PW'($signed(b_i));
        p   = a_x * b_x;
        // q holds the product aligned to Qm.n; every bit above the result sign must match it
        q   = p >>> N_SIZE;
        mult_sat = !((&q[PW-1:TOP_LSB]) || !(|q[PW-1:TOP_LSB]));
        mult_res = mult_sat ? (q[PW-1] ? MIN_V : MAX_V) : q[WORD_SIZE-1:0];

        s       = {acc_r[WORD_SIZE-1], acc_r} + {prod_r[WORD_SIZE-1], prod_r};
        add_sat = s[WORD_SIZE] ^ s[WORD_SIZE-1];
        add_res = add_sat ? (s[WORD_SIZE] ? MIN_V : MAX_V) : s[WORD_SIZE-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= S_LOAD;
            cnt      <= '0;
            acc_r    <= '0;
            prod_r   <= '0;
            prod_v_r <= 1'b0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            data_o   <= '0;
`ifdef SAFE_MAC_SAT_FLAG_EN
            sat_o    <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        cnt      <= cnt + 1'b1;
                        prod_r   <= mult_res;
                        prod_v_r <= 1'b1;
                        if (cnt == '0) acc_r <= bias_i;
                        else if (prod_v_r) acc_r <= add_res;
`ifdef SAFE_MAC_SAT_FLAG_EN
                        if (cnt == '0) sat_o <= mult_sat;
                        else sat_o <= sat_o | mult_sat | (prod_v_r & add_sat);
`endif
                        if (cnt == CW'(LENGTH - 1)) begin
                            state   <= S_DRAIN;
                            ready_o <= 1'b0;
                        end
                    end else begin
                        // a gap still retires the product registered on the previous accept
                        prod_v_r <= 1'b0;
                        if (prod_v_r) acc_r <= add_res;
`ifdef SAFE_MAC_SAT_FLAG_EN
                        if (prod_v_r) sat_o <= sat_o | add_sat;
`endif
                    end
                end
                S_DRAIN: begin
                    acc_r    <= add_res;
                    data_o   <= add_res;
                    prod_v_r <= 1'b0;
                    valid_o  <= 1'b1;
                    state    <= S_DONE;
`ifdef SAFE_MAC_SAT_FLAG_EN
                    sat_o    <= sat_o | add_sat;
`endif
                end
                S_DONE: begin
                    if (ready_i) begin
                        cnt     <= '0;
                        acc_r   <= '0;
                        data_o  <= '0;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                default: begin
                    state   <= S_LOAD;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safe_mac_sequencer.sv
// Bench for safe_mac_sequencer (Q2.14, LENGTH=4): directed cases plus random dot products
// checked against an integer-arithmetic model of the saturating dot product.
module tb_safe_mac_sequencer;
    localparam int W = 16;
    localparam int N = 14;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_i = 1'b0;
    logic ready_i = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0, bias_i = '0;
    logic ready_o, valid_o;
    logic [W-1:0] data_o;
`ifdef SAFE_MAC_SAT_FLAG_EN
    logic sat_o;
`endif

    safe_mac_sequencer #(.WORD_SIZE(W), .N_SIZE(N), .M_SIZE(W-N), .LENGTH(L)) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .bias_i(bias_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o)
`ifdef SAFE_MAC_SAT_FLAG_EN
        , .sat_o(sat_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_sat_q[$];
    logic [W-1:0] cur_a[L];
    logic [W-1:0] cur_b[L];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Dot product with exact integer math, clamping after every product and every sum.
    task automatic model(input logic [W-1:0] bias, output logic [W-1:0] res, output logic sat);
        longint acc, p, q;
        acc = longint'($signed(bias));
        sat = 1'b0;
        for (int k = 0; k < L; k++) begin
            p = longint'($signed(cur_a[k])) * longint'($signed(cur_b[k]));
            q = p >>> N;
            if (q > 32767) begin q = 32767; sat = 1'b1; end
            if (q < -32768) begin q = -32768; sat = 1'b1; end
            acc = acc + q;
            if (acc > 32767) begin acc = 32767; sat = 1'b1; end
            if (acc < -32768) begin acc = -32768; sat = 1'b1; end
        end
        res = acc[W-1:0];
    endtask

    // Compare process: whenever a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (exp_q.size() == 0) chk("cmp_pending", exp_q.size(), 1);
            else begin
                chk("cmp_data", data_o, exp_q[0]);
                chk("cmp_ready_low", ready_o, 0);
`ifdef SAFE_MAC_SAT_FLAG_EN
                chk("cmp_sat", sat_o, exp_sat_q[0]);
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && valid_o && ready_i && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_sat_q.pop_front());
        end
    end

    task automatic run_dot(input string name, input logic [W-1:0] bias, input bit use_lit,
                           input logic [W-1:0] lit, input int gmin, input int gmax,
                           input int hold0);
        logic [W-1:0] er;
        logic es;
        int t;
        bit done;
        model(bias, er, es);
        if (use_lit) chk({"model_", name}, er, lit);
        exp_q.push_back(er);
        exp_sat_q.push_back(es);
        for (int k = 0; k < L; k++) begin
            if (k > 0) begin
                int g = $urandom_range(gmin, gmax);
                valid_i = 1'b0;
                repeat (g) @(negedge clk);
            end
            t = 0;
            while (!ready_o && t < 50) begin @(negedge clk); t++; end
            if (!ready_o) chk({"ready_timeout_", name}, ready_o, 1);
            valid_i = 1'b1;
            a_i = cur_a[k];
            b_i = cur_b[k];
            bias_i = (k == 0) ? bias : W'($urandom);
            @(negedge clk);
        end
        // drain cycle: junk offered while ready_o is low must be ignored
        valid_i = 1'($urandom_range(0, 1));
        a_i = W'($urandom);
        b_i = W'($urandom);
        chk({"drain_valid_", name}, valid_o, 0);
        chk({"drain_ready_", name}, ready_o, 0);
        @(negedge clk);
        chk({"valid_lat_", name}, valid_o, 1);
        chk({"result_", name}, data_o, er);
        t = 0;
        done = 1'b0;
        while (!done && t < 60) begin
            ready_i = (t < hold0) ? 1'b0 : (($urandom_range(0, 2) != 0) || (t > hold0 + 8));
            valid_i = 1'($urandom_range(0, 1));
            a_i = W'($urandom);
            b_i = W'($urandom);
            @(posedge clk);
            done = ready_i;
            @(negedge clk);
            if (!done) begin
                chk({"hold_valid_", name}, valid_o, 1);
                chk({"hold_data_", name}, data_o, er);
                chk({"hold_ready_", name}, ready_o, 0);
            end
            t++;
        end
        if (!done) chk({"handoff_timeout_", name}, done, 1);
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk({"post_ready_", name}, ready_o, 1);
        chk({"post_valid_", name}, valid_o, 0);
        chk({"post_data_", name}, data_o, 0);
    endtask

    task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < L; k++) begin cur_a[k] = a; cur_b[k] = b; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] er;
        logic es;
        @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);
        chk("reset_data", data_o, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        set_all(16'h4000, 16'h1000);
        run_dot("basic", 16'h0000, 1, 16'h4000, 0, 0, 0);

        set_all(16'h4000, 16'h2000);
        model(16'h0000, er, es);
        chk("model_addsat_flag", es, 1);
        run_dot("addsat", 16'h0000, 1, 16'h7FFF, 0, 0, 0);

        set_all(16'h7FFF, 16'h7FFF);
        run_dot("multsat_pos", 16'h0000, 1, 16'h7FFF, 0, 0, 0);
        set_all(16'h8000, 16'h7FFF);
        run_dot("multsat_neg", 16'h0000, 1, 16'h8000, 0, 0, 0);

        // clamp then recover: 7FFF, 7FFF (clamped), -2.0 -> -1 LSB, +1.0 -> 0x3FFF
        cur_a[0] = 16'h7FFF; cur_b[0] = 16'h7FFF;
        cur_a[1] = 16'h7FFF; cur_b[1] = 16'h7FFF;
        cur_a[2] = 16'h8000; cur_b[2] = 16'h4000;
        cur_a[3] = 16'h4000; cur_b[3] = 16'h4000;
        run_dot("resume", 16'h0000, 1, 16'h3FFF, 0, 0, 0);

        set_all(16'h4000, 16'h1000);
        run_dot("gaps_hold", 16'h0000, 1, 16'h4000, 1, 1, 10);
        run_dot("bias", 16'hC000, 1, 16'h0000, 0, 0, 0);

        // reset after the second accept discards the partial sum
        valid_i = 1'b1; a_i = 16'h4000; b_i = 16'h1000; bias_i = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ready", ready_o, 1);
        chk("midreset_valid", valid_o, 0);
        chk("midreset_data", data_o, 0);
        @(negedge clk);
        chk("midreset_ready_next", ready_o, 1);
        chk("midreset_valid_next", valid_o, 0);
        chk("midreset_data_next", data_o, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_dot("after_reset", 16'h0000, 1, 16'h4000, 0, 0, 0);

        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < L; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cur_a[k] = W'($urandom);
                    cur_b[k] = W'($urandom);
                end else begin
                    cur_a[k] = W'($urandom_range(0, 16'h7FFF) - 32'h4000);
                    cur_b[k] = W'($urandom_range(0, 16'h7FFF) - 32'h4000);
                end
            end
            run_dot("random", W'($urandom), 0, 16'h0000, 0, 2, $urandom_range(0, 3));
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
